// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and saturation limits for the registered CLA adder.
package adder_pkg;
  localparam int DATA_W = 32;
  localparam int GROUP_W = 4;
  localparam logic [DATA_W-1:0] SAT_POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
endpackage

// File: rtl/cla_group.sv
// cla_group: GROUP-bit carry-lookahead slice.
// Ports: a, b operands; cin carry in; sum slice sum; g/p group generate/propagate; cout carry out.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = GROUP_W
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p,
  output logic             cout
);
  logic [GROUP-1:0] gi, pi, t, pr;
  logic [GROUP:0] c;
  assign gi = a & b;
  assign pi = a ^ b;
  // t[i]: carry out of bit i assuming cin=0; pr[i]: AND of propagates over bits i..0.
  always_comb begin
    t = '0;
    pr = '0;
    for (int i = 0; i < GROUP; i++) begin
      t[i] = gi[i];
      pr[i] = pi[i];
      for (int j = i - 1; j >= 0; j--) begin
        t[i] = t[i] | (pr[i] & gi[j]);
        pr[i] = pr[i] & pi[j];
      end
    end
  end
  assign c = {t | (pr & {GROUP{cin}}), cin};
  assign sum = pi ^ c[GROUP-1:0];
  assign g = t[GROUP-1];
  assign p = pr[GROUP-1];
  assign cout = c[GROUP];
endmodule

// File: rtl/adder.sv
// adder: registered two-operand adder built from rippled carry-lookahead groups.
// Ports: clk, rst_n (sync, active-low); in_valid, number1, number2, carry_in in;
// res, out_valid, carry_out, overflow, zero, negative out (one cycle later).
// Option: define ADDER_SATURATE_EN to clamp res to the signed extreme on overflow.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int GROUP = GROUP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  input  logic             carry_in,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int N = WIDTH / GROUP;
  logic [WIDTH-1:0] sum, r;
  logic [N:0] c;
  logic [N-1:0] gg, pg, unused_cout;
  logic ov;
  assign c[0] = carry_in;
  for (genvar k = 0; k < N; k++) begin : g_cla
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (number1[k*GROUP +: GROUP]),
      .b   (number2[k*GROUP +: GROUP]),
      .cin (c[k]),
      .sum (sum[k*GROUP +: GROUP]),
      .g   (gg[k]),
      .p   (pg[k]),
      .cout(unused_cout[k])
    );
    // Inter-group carry from group generate/propagate, rippled group to group.
    assign c[k+1] = gg[k] | (pg[k] & c[k]);
  end
  assign ov = (number1[WIDTH-1] == number2[WIDTH-1]) && (sum[WIDTH-1] != number1[WIDTH-1]);
`ifdef ADDER_SATURATE_EN
  // Overflow direction follows the operand sign: negative operands clamp low.
  assign r = ov ? (number1[WIDTH-1] ? SAT_NEG_MIN : SAT_POS_MAX) : sum;
`else
  assign r = sum;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res <= '0;
      out_valid <= 1'b0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res <= r;
        carry_out <= c[N];
        overflow <= ov;
        zero <= (r == '0);
        negative <= r[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for the registered adder.
module tb_adder;
  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  logic clk = 0, rst_n = 0, in_valid = 0, carry_in = 0;
  logic [31:0] number1 = 0, number2 = 0, res;
  logic out_valid, carry_out, overflow, zero, negative;
  int total = 0, bad = 0;
  exp_t q[$];
  exp_t e, obs_v;

  adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .number1(number1), .number2(number2),
    .carry_in(carry_in), .res(res), .out_valid(out_valid), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  assign obs_v = {res, carry_out, overflow, zero, negative};

`ifdef ADDER_SATURATE_EN
  localparam exp_t E_MINMIN = {32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam exp_t E_MAXP1  = {32'h7fffffff, 1'b0, 1'b1, 1'b0, 1'b0};
`else
  localparam exp_t E_MINMIN = {32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam exp_t E_MAXP1  = {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] t;
    logic [31:0] r;
    logic v;
    t = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    v = (a[31] == b[31]) && (t[31] != a[31]);
    r = t[31:0];
`ifdef ADDER_SATURATE_EN
    if (v) r = a[31] ? 32'h80000000 : 32'h7fffffff;
`endif
    return {r, t[32], v, r == 32'h0, r[31]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    in_valid = v;
    number1 = a;
    number2 = b;
    carry_in = cin;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hffffffff, 32'h1, 1'b1);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || obs_v !== '0) begin
        bad++;
        $display("FAIL reset[%0d] got valid=%b out=%h want valid=0 out=0", i, out_valid, obs_v);
      end
    end
    rst_n = 1;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'h80000000, 32'h80000000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    number1 = 32'h7fffffff;
    number2 = 32'h1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || obs_v !== '0) begin
      bad++;
      $display("FAIL reset_mid got valid=%b out=%h want valid=0 out=0", out_valid, obs_v);
    end
    @(negedge clk);
    rst_n = 1;
    in_valid = 0;
  endtask

  task automatic test_directed;
    logic [31:0] da[7] = '{32'h65654540, 32'h80000000, 32'h80000000, 32'h7fffffff,
                           32'hffffffff, 32'hffffffff, 32'h00000001};
    logic [31:0] db[7] = '{32'h80000001, 32'h80000000, 32'h00000007, 32'h00000001,
                           32'h00000000, 32'h00000001, 32'h00000002};
    logic dc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t de[7];
    de[0] = {32'he5654541, 1'b0, 1'b0, 1'b0, 1'b1};
    de[1] = E_MINMIN;
    de[2] = {32'h80000007, 1'b0, 1'b0, 1'b0, 1'b1};
    de[3] = E_MAXP1;
    de[4] = {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    de[5] = {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    de[6] = {32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, da[i], db[i], dc[i]);
      q.push_back(de[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      total++;
      if (out_valid !== 1'b1 || obs_v !== e) begin
        bad++;
        $display("FAIL directed[%0d] got valid=%b out=%h want valid=1 out=%h", i, out_valid, obs_v, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic [31:0] last = 0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      drive(1'b1, a, b, i[0]);
      q.push_back(model(a, b, i[0]));
      @(posedge clk); #1;
      e = q.pop_front();
      last = e.res;
      total++;
      if (out_valid !== 1'b1 || obs_v !== e) begin
        bad++;
        $display("FAIL b2b[%0d] got valid=%b out=%h want valid=1 out=%h", i, out_valid, obs_v, e);
      end
    end
    drive(1'b0, 32'h12345678, 32'h1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || res !== last) begin
      bad++;
      $display("FAIL b2b_idle got valid=%b res=%h want valid=0 res=%h", out_valid, res, last);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [31:0] edges[4] = '{32'h0, 32'hffffffff, 32'h80000000, 32'h7fffffff};
    logic v, cin;
    exp_t hold;
    hold = obs_v;
    for (int i = 0; i < 10000; i++) begin
      a = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      cin = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 7) != 0);
      drive(v, a, b, cin);
      if (v) q.push_back(model(a, b, cin));
      @(posedge clk); #1;
      total++;
      if (v) begin
        e = q.pop_front();
        hold = e;
        if (out_valid !== 1'b1 || obs_v !== e) begin
          bad++;
          $display("FAIL random[%0d] got valid=%b out=%h want valid=1 out=%h", i, out_valid, obs_v, e);
        end
      end else if (out_valid !== 1'b0 || obs_v !== hold) begin
        bad++;
        $display("FAIL random_idle[%0d] got valid=%b out=%h want valid=0 out=%h", i, out_valid, obs_v, hold);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder.md
Name: adder

Overview:
32-bit two-operand integer adder used in the pipelined MIPS datapath (PC+4, branch-target and address arithmetic). Registered single-stage: operands sampled on a clock edge; sum and status flags presented one cycle later. Built from carry-lookahead groups so timing closes at the pipeline clock.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4.
GROUP, 4, carry-lookahead group width in bits.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands valid this cycle
number1  input  WIDTH  operand A
number2  input  WIDTH  operand B
carry_in  input  1  carry into bit 0; tie 0 for plain add
res  output  WIDTH  registered sum
out_valid  output  1  res and flags valid
carry_out  output  1  unsigned carry out of the MSB
overflow  output  1  signed two's-complement overflow
zero  output  1  res == 0
negative  output  1  res[WIDTH-1]

Behaviour:
- One clock; reset is synchronous and active-low (ports clk, rst_n).
- Reset: on a rising edge with rst_n=0, res=0, out_valid=0, carry_out=0, overflow=0, zero=0, negative=0. Reset wins over a simultaneous in_valid. Reset mid-operation discards the sample in flight.
- Latency 1: an edge with in_valid=1 registers {carry_out,res} = number1 + number2 + carry_in (modulo 2^WIDTH for res). out_valid=1 in the following cycle.
- Edge with in_valid=0: out_valid <= 0; res and all flags hold their previous values.
- No backpressure; a new result is accepted every cycle (full throughput).
- overflow = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
- zero and negative are computed from the value actually registered into res (post-saturation when that option is on).
- Carry chain: WIDTH/GROUP lookahead groups, each producing generate/propagate; group carries are rippled between groups. The result must be bit-exact to behavioural "+".
- Wrap-around: 0xFFFFFFFF + 1 gives res=0, carry_out=1, zero=1, overflow=0.

Optional Feature:
ADDER_SATURATE_EN
- Defined: when overflow=1, res is clamped to the signed extreme: positive overflow gives 0x7FFFFFFF; negative overflow gives 0x80000000. The overflow flag still reports 1. carry_out is unchanged (raw).
- Undefined: res always wraps modulo 2^WIDTH; no clamp logic is present.

Decomposition:
- Package adder_pkg: WIDTH/GROUP defaults; constants SAT_POS_MAX and SAT_NEG_MIN.
- Sub-module cla_group: GROUP-bit carry-lookahead slice (inputs a, b, cin; outputs sum, g, p, cout), instantiated WIDTH/GROUP times by a generate loop.
- Flag, saturation and output registers live in adder.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 for 2 cycles -> res=0, out_valid=0, all flags 0.
- 0x65654540 + 0x80000001, cin=0 -> next cycle res=0xE5654541, carry_out=0, overflow=0, negative=1, zero=0.
- 0x80000000 + 0x80000000 -> res=0x00000000, carry_out=1, overflow=1, zero=1. With ADDER_SATURATE_EN: res=0x80000000, zero=0, negative=1.
- 0x80000000 + 0x00000007 -> res=0x80000007, carry_out=0, overflow=0, negative=1.
- 0x7FFFFFFF + 1 -> res=0x80000000, overflow=1 (saturated build: res=0x7FFFFFFF). 0xFFFFFFFF + 0, cin=1 -> res=0, carry_out=1, zero=1.
- Back-to-back valids for 3 cycles, then in_valid=0 -> each result appears one cycle after its inputs; out_valid drops while res holds the last sum. Random 10k-vector compare against behavioural "+".
